// File: rtl/controle_varredura_servo_if.sv
// ---------------------------------------------------------------------------
// controle_varredura_servo_if
// Purpose : bundles the control inputs and position/status outputs of the
//           servo sweep sequencer so that the sequencer and its driver share
//           one port.
// Signals : ligar         run (1) / return to rest (0), driven by master
//           pausa         freeze sweep, driven by master (SERVO_PAUSA_EN only)
//           largura[2:0]  position code towards circuito_pwm, driven by slave
//           ativo         sweep running, driven by slave
//           fim_varredura one-clock pulse at end of sweep, driven by slave
//           db_estado[1:0] debug state code, driven by slave
// Macro   : SERVO_PAUSA_EN adds the pausa signal.
// ---------------------------------------------------------------------------
interface controle_varredura_servo_if;
  logic       ligar;
`ifdef SERVO_PAUSA_EN
  logic       pausa;
`endif
  logic [2:0] largura;
  logic       ativo;
  logic       fim_varredura;
  logic [1:0] db_estado;

  modport master (
    output ligar,
    input  largura,
    input  ativo,
    input  fim_varredura,
    input  db_estado
`ifdef SERVO_PAUSA_EN
    , output pausa
`endif
  );

  modport slave (
    input  ligar,
    output largura,
    output ativo,
    output fim_varredura,
    output db_estado
`ifdef SERVO_PAUSA_EN
    , input pausa
`endif
  );
endinterface

// File: rtl/controle_varredura_servo.sv
// ---------------------------------------------------------------------------
// controle_varredura_servo
// Purpose : sweeps the 3-bit largura code of circuito_pwm ping-pong through
//           000..111..001 and back to 000, holding every position for
//           CONF_PERIODO*CICLOS_POR_POSICAO clocks, repeating while ligar=1.
// Ports   : clock  system clock, rising edge
//           reset  synchronous, active-low
//           bus    controle_varredura_servo_if.slave
//                  (ligar, [pausa], largura, ativo, fim_varredura, db_estado)
// Params  : CONF_PERIODO        clocks per PWM period (>=2)
//           CICLOS_POR_POSICAO  PWM periods per position (>=1)
// Macro   : SERVO_PAUSA_EN enables the pausa freeze input; without it the
//           sweep never freezes.
// All outputs come straight from flops.
// ---------------------------------------------------------------------------
module controle_varredura_servo #(
  parameter int CONF_PERIODO       = 1000000,
  parameter int CICLOS_POR_POSICAO = 2
) (
  input  logic                         clock,
  input  logic                         reset,
  controle_varredura_servo_if.slave    bus
);

  localparam int CW = (CONF_PERIODO > 1)       ? $clog2(CONF_PERIODO)       : 1;
  localparam int PW = (CICLOS_POR_POSICAO > 1) ? $clog2(CICLOS_POR_POSICAO) : 1;

  localparam logic [CW-1:0] CLK_MAX  = CW'(CONF_PERIODO - 1);
  localparam logic [PW-1:0] PER_MAX  = PW'(CICLOS_POR_POSICAO - 1);
  localparam logic [CW-1:0] CLK_ONE  = CW'(32'd1);
  localparam logic [PW-1:0] PER_ONE  = PW'(32'd1);
  localparam logic [CW-1:0] CLK_ZERO = {CW{1'b0}};
  localparam logic [PW-1:0] PER_ZERO = {PW{1'b0}};

  localparam logic [1:0] INICIAL  = 2'b00;
  localparam logic [1:0] SUBINDO  = 2'b01;
  localparam logic [1:0] DESCENDO = 2'b10;

  logic [1:0]    state_q,   state_d;
  logic [2:0]    largura_q, largura_d;
  logic [CW-1:0] cnt_clk_q, cnt_clk_d;
  logic [PW-1:0] cnt_per_q, cnt_per_d;
  logic          ativo_q,   ativo_d;
  logic          fim_q,     fim_d;
  logic          pausa_s;
  logic          tick_s;

`ifdef SERVO_PAUSA_EN
  assign pausa_s = bus.pausa;
`else
  assign pausa_s = 1'b0;
`endif

  // End of the current hold: last clock of the last PWM period.
  assign tick_s = (cnt_clk_q == CLK_MAX) && (cnt_per_q == PER_MAX);

  // Next-state logic: priority is ligar==0 > pausa > tick > counting.
  always_comb begin
    state_d   = state_q;
    largura_d = largura_q;
    cnt_clk_d = cnt_clk_q;
    cnt_per_d = cnt_per_q;
    fim_d     = 1'b0;
    case (state_q)
      INICIAL: begin
        largura_d = 3'b000;
        cnt_clk_d = CLK_ZERO;
        cnt_per_d = PER_ZERO;
        if (bus.ligar) begin
          state_d = SUBINDO;
        end else begin
          state_d = INICIAL;
        end
      end
      SUBINDO, DESCENDO: begin
        if (!bus.ligar) begin
          // Abandon the sweep; any partial hold is discarded.
          state_d   = INICIAL;
          largura_d = 3'b000;
          cnt_clk_d = CLK_ZERO;
          cnt_per_d = PER_ZERO;
        end else if (pausa_s) begin
          state_d = state_q;
        end else if (tick_s) begin
          cnt_clk_d = CLK_ZERO;
          cnt_per_d = PER_ZERO;
          if (state_q == SUBINDO) begin
            largura_d = largura_q + 3'd1;
            // Reaching 111 turns around immediately so 111 is held once.
            if (largura_q == 3'b110) begin
              state_d = DESCENDO;
            end else begin
              state_d = SUBINDO;
            end
          end else begin
            largura_d = largura_q - 3'd1;
            // Landing on 000 closes the sweep; 000 then counts as the first
            // hold of the next rising half, so it is not held twice.
            if (largura_q == 3'b001) begin
              fim_d   = 1'b1;
              state_d = SUBINDO;
            end else begin
              state_d = DESCENDO;
            end
          end
        end else if (cnt_clk_q == CLK_MAX) begin
          cnt_clk_d = CLK_ZERO;
          cnt_per_d = cnt_per_q + PER_ONE;
        end else begin
          cnt_clk_d = cnt_clk_q + CLK_ONE;
        end
      end
      default: begin
        state_d   = INICIAL;
        largura_d = 3'b000;
        cnt_clk_d = CLK_ZERO;
        cnt_per_d = PER_ZERO;
      end
    endcase
    ativo_d = (state_d != INICIAL);
  end

  // State, counter and output registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= INICIAL;
      largura_q <= 3'b000;
      cnt_clk_q <= CLK_ZERO;
      cnt_per_q <= PER_ZERO;
      ativo_q   <= 1'b0;
      fim_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      largura_q <= largura_d;
      cnt_clk_q <= cnt_clk_d;
      cnt_per_q <= cnt_per_d;
      ativo_q   <= ativo_d;
      fim_q     <= fim_d;
    end
  end

  assign bus.largura       = largura_q;
  assign bus.ativo         = ativo_q;
  assign bus.fim_varredura = fim_q;
  assign bus.db_estado     = state_q;

endmodule

// File: tb/tb_controle_varredura_servo.sv
// ---------------------------------------------------------------------------
// tb_controle_varredura_servo
// Bench for the servo sweep sequencer with CONF_PERIODO=10,
// CICLOS_POR_POSICAO=2 (hold of 20 clocks). The reference model tracks only
// "running or not" and the number of un-paused clocks since the sweep
// started; position, direction and end-of-sweep follow from that count by
// plain arithmetic. Define SERVO_PAUSA_EN to also exercise pausa.
// ---------------------------------------------------------------------------
module tb_controle_varredura_servo;

  localparam int HOLD = 20;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  controle_varredura_servo_if bus ();

  controle_varredura_servo #(
    .CONF_PERIODO       (10),
    .CICLOS_POR_POSICAO (2)
  ) dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  bit model_on;
  int model_elapsed;
  bit model_fim;

  function automatic int m_pos();
    return (model_elapsed / HOLD) % 14;
  endfunction

  function automatic logic [2:0] m_largura();
    int p;
    if (!model_on) return 3'b000;
    p = m_pos();
    return (p <= 7) ? 3'(p) : 3'(14 - p);
  endfunction

  function automatic logic [1:0] m_estado();
    if (!model_on) return 2'b00;
    return (m_pos() >= 7) ? 2'b10 : 2'b01;
  endfunction

  // Apply inputs for one clock, advance the model, settle 1 time unit after the edge.
  task automatic step(input logic r, input logic lig, input logic pau);
    bit eff_pau;
    rst_n     = r;
    bus.ligar = lig;
`ifdef SERVO_PAUSA_EN
    bus.pausa = pau;
    eff_pau   = pau;
`else
    eff_pau   = 1'b0;
`endif
    @(posedge clk);
    model_fim = 1'b0;
    if (!r || !lig) begin
      model_on = 1'b0;
      model_elapsed = 0;
    end else if (!model_on) begin
      model_on = 1'b1;
      model_elapsed = 0;
    end else if (!eff_pau) begin
      model_elapsed++;
      if ((model_elapsed % HOLD == 0) && (m_pos() == 0)) model_fim = 1'b1;
    end
    #1;
  endtask

  task automatic test_reset();
    step(1'b0, 1'b1, 1'b0);
    checks++; if (bus.largura !== 3'b000) begin errors++; $display("FAIL reset_largura got=%b exp=000", bus.largura); end
    checks++; if (bus.ativo !== 1'b0) begin errors++; $display("FAIL reset_ativo got=%b exp=0", bus.ativo); end
    checks++; if (bus.fim_varredura !== 1'b0) begin errors++; $display("FAIL reset_fim got=%b exp=0", bus.fim_varredura); end
    checks++; if (bus.db_estado !== 2'b00) begin errors++; $display("FAIL reset_estado got=%b exp=00", bus.db_estado); end
  endtask

  task automatic test_sweep();
    int fim_count;
    fim_count = 0;
    step(1'b1, 1'b1, 1'b0);
    checks++; if (bus.db_estado !== 2'b01 || bus.ativo !== 1'b1 || bus.largura !== 3'b000) begin
      errors++; $display("FAIL sweep_start got est=%b ativo=%b lar=%b exp est=01 ativo=1 lar=000", bus.db_estado, bus.ativo, bus.largura);
    end
    for (int k = 1; k <= 300; k++) begin
      step(1'b1, 1'b1, 1'b0);
      if (bus.fim_varredura === 1'b1) fim_count++;
      checks++; if (bus.largura !== m_largura()) begin errors++; $display("FAIL sweep_track k=%0d got=%b exp=%b", k, bus.largura, m_largura()); end
      case (k)
        20:  begin checks++; if (bus.largura !== 3'b001) begin errors++; $display("FAIL sweep_t20 got=%b exp=001", bus.largura); end end
        40:  begin checks++; if (bus.largura !== 3'b010) begin errors++; $display("FAIL sweep_t40 got=%b exp=010", bus.largura); end end
        140: begin checks++; if (bus.largura !== 3'b111 || bus.db_estado !== 2'b10) begin errors++; $display("FAIL sweep_t140 got=%b/%b exp=111/10", bus.largura, bus.db_estado); end end
        160: begin checks++; if (bus.largura !== 3'b110) begin errors++; $display("FAIL sweep_t160 got=%b exp=110", bus.largura); end end
        260: begin checks++; if (bus.largura !== 3'b001) begin errors++; $display("FAIL sweep_t260 got=%b exp=001", bus.largura); end end
        280: begin checks++; if (bus.largura !== 3'b000 || bus.fim_varredura !== 1'b1) begin errors++; $display("FAIL sweep_t280 got=%b fim=%b exp=000 fim=1", bus.largura, bus.fim_varredura); end end
        281: begin checks++; if (bus.fim_varredura !== 1'b0) begin errors++; $display("FAIL sweep_fim_width got=%b exp=0", bus.fim_varredura); end end
        300: begin checks++; if (bus.largura !== 3'b001 || bus.db_estado !== 2'b01) begin errors++; $display("FAIL sweep_t300 got=%b/%b exp=001/01", bus.largura, bus.db_estado); end end
        default: ;
      endcase
    end
    checks++; if (fim_count != 1) begin errors++; $display("FAIL sweep_fim_count got=%0d exp=1", fim_count); end
  endtask

  task automatic test_ligar_drop();
    // 001 was just reached; 011 arrives two holds later.
    repeat (2 * HOLD) step(1'b1, 1'b1, 1'b0);
    checks++; if (bus.largura !== 3'b011) begin errors++; $display("FAIL drop_at011 got=%b exp=011", bus.largura); end
    repeat (5) step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    checks++; if (bus.largura !== 3'b000 || bus.ativo !== 1'b0 || bus.db_estado !== 2'b00) begin
      errors++; $display("FAIL drop_rest got lar=%b ativo=%b est=%b exp 000/0/00", bus.largura, bus.ativo, bus.db_estado);
    end
    step(1'b1, 1'b1, 1'b0);
    repeat (HOLD - 1) step(1'b1, 1'b1, 1'b0);
    checks++; if (bus.largura !== 3'b000) begin errors++; $display("FAIL drop_hold19 got=%b exp=000", bus.largura); end
    step(1'b1, 1'b1, 1'b0);
    checks++; if (bus.largura !== 3'b001) begin errors++; $display("FAIL drop_hold20 got=%b exp=001", bus.largura); end
  endtask

  task automatic test_reset_mid();
    // From 001 rising, eight more holds reach 101 on the way down.
    repeat (8 * HOLD) step(1'b1, 1'b1, 1'b0);
    checks++; if (bus.largura !== 3'b101 || bus.db_estado !== 2'b10) begin errors++; $display("FAIL mid_at101 got=%b/%b exp=101/10", bus.largura, bus.db_estado); end
    step(1'b0, 1'b1, 1'b0);
    checks++; if (bus.largura !== 3'b000 || bus.ativo !== 1'b0 || bus.db_estado !== 2'b00 || bus.fim_varredura !== 1'b0) begin
      errors++; $display("FAIL mid_reset got lar=%b ativo=%b est=%b fim=%b exp 000/0/00/0", bus.largura, bus.ativo, bus.db_estado, bus.fim_varredura);
    end
    step(1'b1, 1'b1, 1'b0);
    repeat (HOLD) step(1'b1, 1'b1, 1'b0);
    checks++; if (bus.largura !== 3'b001 || bus.db_estado !== 2'b01) begin errors++; $display("FAIL mid_restart got=%b/%b exp=001/01", bus.largura, bus.db_estado); end
  endtask

`ifdef SERVO_PAUSA_EN
  task automatic test_pause();
    repeat (HOLD) step(1'b1, 1'b1, 1'b0);
    checks++; if (bus.largura !== 3'b010) begin errors++; $display("FAIL pause_at010 got=%b exp=010", bus.largura); end
    repeat (5) step(1'b1, 1'b1, 1'b0);
    repeat (7) step(1'b1, 1'b1, 1'b1);
    repeat (14) step(1'b1, 1'b1, 1'b0);
    checks++; if (bus.largura !== 3'b010) begin errors++; $display("FAIL pause_c26 got=%b exp=010", bus.largura); end
    step(1'b1, 1'b1, 1'b0);
    checks++; if (bus.largura !== 3'b011) begin errors++; $display("FAIL pause_c27 got=%b exp=011", bus.largura); end
    repeat (HOLD - 1) step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    checks++; if (bus.largura !== 3'b011) begin errors++; $display("FAIL pause_on_tick got=%b exp=011", bus.largura); end
    step(1'b1, 1'b1, 1'b0);
    checks++; if (bus.largura !== 3'b100) begin errors++; $display("FAIL pause_resume got=%b exp=100", bus.largura); end
  endtask
`endif

  task automatic test_random();
    logic r, lig, pau;
    for (int n = 0; n < 3000; n++) begin
      r   = ($urandom_range(0, 299) != 0);
      lig = ($urandom_range(0, 59) != 0);
`ifdef SERVO_PAUSA_EN
      pau = ($urandom_range(0, 5) == 0);
`else
      pau = 1'b0;
`endif
      step(r, lig, pau);
      checks++;
      if (bus.largura !== m_largura() || bus.db_estado !== m_estado() ||
          bus.ativo !== model_on || bus.fim_varredura !== model_fim) begin
        errors++;
        $display("FAIL random n=%0d got lar=%b est=%b ativo=%b fim=%b exp lar=%b est=%b ativo=%b fim=%b",
                 n, bus.largura, bus.db_estado, bus.ativo, bus.fim_varredura,
                 m_largura(), m_estado(), model_on, model_fim);
      end
    end
  endtask

  initial begin
    errors        = 0;
    checks        = 0;
    model_on      = 1'b0;
    model_elapsed = 0;
    model_fim     = 1'b0;
    rst_n         = 1'b0;
    bus.ligar     = 1'b0;
`ifdef SERVO_PAUSA_EN
    bus.pausa     = 1'b0;
`endif
    test_reset();
    test_sweep();
    test_ligar_drop();
    test_reset_mid();
`ifdef SERVO_PAUSA_EN
    test_pause();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
